// File: rtl/looper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : looper_pkg
// Description : Shared types, limits and helpers for the audio looper
//               controller (mode FSM, SRAM access sequencer, saturation).
// Revision    : 1.0 - initial release
// ============================================================================
package looper_pkg;

    // Looper operating mode; encoding is visible on o_state.
    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_REC  = 2'd1,
        MODE_PLAY = 2'd2
    } mode_t;

    // SRAM access sequencer states.
    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_WRITE = 2'd1,
        SEQ_READ  = 2'd2,
        SEQ_DUB   = 2'd3
    } seq_t;

    // User command held while the sequencer is busy.
    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_REC  = 2'd1,
        CMD_STOP = 2'd2
    } cmd_t;

    localparam logic [19:0] MAX_ADDR = 20'hFFFFF;
    localparam logic [15:0] SAT_MAX  = 16'h7FFF;
    localparam logic [15:0] SAT_MIN  = 16'h8000;

    // Signed 16-bit add clamped to [-32768, 32767].
    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {a[15], a} + {b[15], b};
        case (sum[16:15])
            2'b01:   sat_add = SAT_MAX;
            2'b10:   sat_add = SAT_MIN;
            default: sat_add = sum[15:0];
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/looper_sram_seq.sv
`default_nettype none
// ============================================================================
// Module      : looper_sram_seq
// Description : Async SRAM access sequencer. Runs one write (REC) or one
//               read (PLAY) per start pulse, owns all SRAM pins and the DQ
//               tristate, and captures read data for playback.
//               Optional feature macro: LOOPER_OVERDUB_EN (read is followed
//               by a saturated read-modify-write to the same address).
// Revision    : 1.0 - initial release
// ============================================================================
module looper_sram_seq
    import looper_pkg::*;
(
    input  logic        i_AUD_BCLK,
    input  logic        i_rst_n,
    input  logic        start_wr,
    input  logic        start_rd,
    input  logic [19:0] addr,
    input  logic [15:0] wdata,
    input  logic        clear_data,
    output logic        busy,
    output logic [15:0] rd_data,
    output logic [19:0] o_SRAM_ADDR,
    inout  wire  [15:0] io_SRAM_DQ,
    output logic        o_SRAM_WE_N,
    output logic        o_SRAM_CE_N,
    output logic        o_SRAM_OE_N,
    output logic        o_SRAM_LB_N,
    output logic        o_SRAM_UB_N
);

    seq_t        state;
    logic        dq_oe;
    logic [15:0] dq_out;
`ifdef LOOPER_OVERDUB_EN
    logic [15:0] live;
`endif

    assign busy       = (state != SEQ_IDLE);
    // DQ is only ever driven in write cycles, where OE_N is held high.
    assign io_SRAM_DQ = dq_oe ? dq_out : 16'hzzzz;

    // Access state machine with registered SRAM strobes and playback capture.
    always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= SEQ_IDLE;
            dq_oe       <= 1'b0;
            dq_out      <= '0;
            rd_data     <= '0;
            o_SRAM_ADDR <= '0;
            o_SRAM_WE_N <= 1'b1;
            o_SRAM_CE_N <= 1'b1;
            o_SRAM_OE_N <= 1'b1;
            o_SRAM_LB_N <= 1'b1;
            o_SRAM_UB_N <= 1'b1;
`ifdef LOOPER_OVERDUB_EN
            live        <= '0;
`endif
        end else begin
            if (clear_data) begin
                rd_data <= '0;
            end
            case (state)
                SEQ_IDLE: begin
                    if (start_wr) begin
                        state       <= SEQ_WRITE;
                        o_SRAM_ADDR <= addr;
                        dq_out      <= wdata;
                        dq_oe       <= 1'b1;
                        o_SRAM_CE_N <= 1'b0;
                        o_SRAM_WE_N <= 1'b0;
                        o_SRAM_OE_N <= 1'b1;
                        o_SRAM_LB_N <= 1'b0;
                        o_SRAM_UB_N <= 1'b0;
                    end else if (start_rd) begin
                        state       <= SEQ_READ;
                        o_SRAM_ADDR <= addr;
                        dq_oe       <= 1'b0;
                        o_SRAM_CE_N <= 1'b0;
                        o_SRAM_WE_N <= 1'b1;
                        o_SRAM_OE_N <= 1'b0;
                        o_SRAM_LB_N <= 1'b0;
                        o_SRAM_UB_N <= 1'b0;
`ifdef LOOPER_OVERDUB_EN
                        live        <= wdata;
`endif
                    end
                end
                SEQ_READ: begin
                    rd_data <= io_SRAM_DQ;
`ifdef LOOPER_OVERDUB_EN
                    // Release OE before driving the mixed sample back.
                    state       <= SEQ_DUB;
                    o_SRAM_OE_N <= 1'b1;
                    o_SRAM_WE_N <= 1'b0;
                    dq_oe       <= 1'b1;
                    dq_out      <= sat_add(io_SRAM_DQ, live);
`else
                    state       <= SEQ_IDLE;
                    o_SRAM_CE_N <= 1'b1;
                    o_SRAM_OE_N <= 1'b1;
                    o_SRAM_LB_N <= 1'b1;
                    o_SRAM_UB_N <= 1'b1;
`endif
                end
                default: begin
                    // Write or overdub cycle complete: release the bus.
                    state       <= SEQ_IDLE;
                    dq_oe       <= 1'b0;
                    o_SRAM_CE_N <= 1'b1;
                    o_SRAM_WE_N <= 1'b1;
                    o_SRAM_OE_N <= 1'b1;
                    o_SRAM_LB_N <= 1'b1;
                    o_SRAM_UB_N <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/looper_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : looper_ctrl
// Description : Audio looper top. Mode FSM (IDLE/REC/PLAY), loop addressing,
//               command latch, sample acceptance/overrun and o_valid timing.
//               SRAM pin handling lives in looper_sram_seq.
//               Optional feature macro: LOOPER_OVERDUB_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module looper_ctrl
    import looper_pkg::*;
(
    input  logic        i_AUD_BCLK,
    input  logic        i_rst_n,
    input  logic        i_sample_valid,
    input  logic [15:0] i_data,
    input  logic        i_rec,
    input  logic        i_stop,
    output logic [15:0] o_data,
    output logic        o_valid,
    output logic [1:0]  o_state,
    output logic [19:0] o_loop_end,
    output logic        o_overrun,
    output logic [19:0] o_SRAM_ADDR,
    inout  wire  [15:0] io_SRAM_DQ,
    output logic        o_SRAM_WE_N,
    output logic        o_SRAM_CE_N,
    output logic        o_SRAM_OE_N,
    output logic        o_SRAM_LB_N,
    output logic        o_SRAM_UB_N
);

    mode_t       mode;
    cmd_t        pending;
    cmd_t        cmd_new;
    cmd_t        cmd_eff;
    logic        cmd_go;
    logic        busy;
    logic        accept;
    logic        start_wr;
    logic        start_rd;
    logic [19:0] wr_addr;
    logic [19:0] rd_addr;
    logic [19:0] seq_addr;
    logic        valid_d1;

    assign accept   = i_sample_valid && !busy;
    assign start_wr = accept && (mode == MODE_REC);
    assign start_rd = accept && (mode == MODE_PLAY);
    assign seq_addr = start_wr ? wr_addr : rd_addr;
    assign o_state  = mode;

    // Stop outranks record; a fresh command outranks a latched one.
    always_comb begin
        cmd_new = CMD_NONE;
        if (i_stop) begin
            cmd_new = CMD_STOP;
        end else if (i_rec) begin
            cmd_new = CMD_REC;
        end
        cmd_eff = (cmd_new != CMD_NONE) ? cmd_new : pending;
        cmd_go  = !busy && (cmd_eff != CMD_NONE);
    end

    // Mode FSM, loop addressing, command latch and output timing.
    always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode       <= MODE_IDLE;
            pending    <= CMD_NONE;
            wr_addr    <= '0;
            rd_addr    <= '0;
            o_loop_end <= '0;
            o_overrun  <= 1'b0;
            valid_d1   <= 1'b0;
            o_valid    <= 1'b0;
        end else begin
            valid_d1 <= accept;
            o_valid  <= valid_d1;
            if (i_sample_valid && busy) begin
                o_overrun <= 1'b1;
            end
            if (start_wr) begin
                wr_addr <= wr_addr + 20'd1;
            end
            if (start_rd) begin
                rd_addr <= (rd_addr == o_loop_end) ? 20'd0 : rd_addr + 20'd1;
            end
            if (busy) begin
                if (cmd_new != CMD_NONE) begin
                    pending <= cmd_new;
                end
            end else begin
                pending <= CMD_NONE;
            end

            if (cmd_go) begin
                case (cmd_eff)
                    CMD_STOP: mode <= MODE_IDLE;
                    CMD_REC: begin
                        case (mode)
                            MODE_IDLE: begin
                                mode    <= MODE_REC;
                                wr_addr <= '0;
                            end
                            MODE_REC: begin
                                // A write started this same cycle is part of the loop.
                                if (!start_wr && (wr_addr == 20'd0)) begin
                                    mode <= MODE_IDLE;
                                end else begin
                                    mode       <= MODE_PLAY;
                                    o_loop_end <= start_wr ? wr_addr : wr_addr - 20'd1;
                                    rd_addr    <= '0;
                                end
                            end
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end else if (start_wr && (wr_addr == MAX_ADDR)) begin
                // Memory full: close the loop on the last address.
                mode       <= MODE_PLAY;
                o_loop_end <= MAX_ADDR;
                rd_addr    <= '0;
            end
        end
    end

    looper_sram_seq u_seq (
        .i_AUD_BCLK  (i_AUD_BCLK),
        .i_rst_n     (i_rst_n),
        .start_wr    (start_wr),
        .start_rd    (start_rd),
        .addr        (seq_addr),
        .wdata       (i_data),
        .clear_data  (mode != MODE_PLAY),
        .busy        (busy),
        .rd_data     (o_data),
        .o_SRAM_ADDR (o_SRAM_ADDR),
        .io_SRAM_DQ  (io_SRAM_DQ),
        .o_SRAM_WE_N (o_SRAM_WE_N),
        .o_SRAM_CE_N (o_SRAM_CE_N),
        .o_SRAM_OE_N (o_SRAM_OE_N),
        .o_SRAM_LB_N (o_SRAM_LB_N),
        .o_SRAM_UB_N (o_SRAM_UB_N)
    );

endmodule
`default_nettype wire

// File: tb/tb_looper_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_looper_ctrl
// Description : Directed self-checking bench for looper_ctrl with a small
//               behavioural async SRAM (16 words, address bits [3:0]).
//               Overdub checks are built when LOOPER_OVERDUB_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_looper_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] data = '0;
    logic        rec = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] q_data;
    logic        q_valid;
    logic [1:0]  state;
    logic [19:0] loop_end;
    logic        overrun;
    logic [19:0] addr;
    wire  [15:0] dq;
    logic        we_n, ce_n, oe_n, lb_n, ub_n;

    logic [15:0] mem [16];
    int          wr_count = 0;
    int          clash = 0;
    int          oob = 0;
    int          tests = 0;
    int          fails = 0;
    int          w0;

    always #5 clk = ~clk;

    looper_ctrl dut (
        .i_AUD_BCLK     (clk),
        .i_rst_n        (rst_n),
        .i_sample_valid (sample_valid),
        .i_data         (data),
        .i_rec          (rec),
        .i_stop         (stop),
        .o_data         (q_data),
        .o_valid        (q_valid),
        .o_state        (state),
        .o_loop_end     (loop_end),
        .o_overrun      (overrun),
        .o_SRAM_ADDR    (addr),
        .io_SRAM_DQ     (dq),
        .o_SRAM_WE_N    (we_n),
        .o_SRAM_CE_N    (ce_n),
        .o_SRAM_OE_N    (oe_n),
        .o_SRAM_LB_N    (lb_n),
        .o_SRAM_UB_N    (ub_n)
    );

    // Async SRAM: reads drive DQ combinationally, writes commit mid-cycle.
    assign dq = (!ce_n && !oe_n && we_n) ? mem[addr[3:0]] : 16'hzzzz;

    always @(negedge clk) begin
        if (rst_n && !ce_n && !we_n) begin
            mem[addr[3:0]] = dq;
            wr_count++;
        end
        if (!oe_n && !we_n) clash++;
        if (!ce_n && addr[19:4] != 16'd0) oob++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_cmd(input logic r, input logic s);
        rec  = r;
        stop = s;
        tick();
        rec  = 1'b0;
        stop = 1'b0;
    endtask

    // Returns one cycle after the accepting edge (first access cycle).
    task automatic sample(input logic [15:0] v);
        data         = v;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic rec_sample(input logic [15:0] v, input logic [19:0] a);
        sample(v);
        chk("rec_we", {31'd0, we_n}, 32'd0);
        chk("rec_addr", {12'd0, addr}, {12'd0, a});
        chk("rec_valid_early", {31'd0, q_valid}, 32'd0);
        tick();
        chk("rec_valid", {31'd0, q_valid}, 32'd1);
        chk("rec_data_zero", {16'd0, q_data}, 32'd0);
        tick();
    endtask

    task automatic play_sample(input logic [15:0] live, input logic [15:0] exp);
        sample(live);
        chk("play_oe", {30'd0, oe_n, we_n}, 32'd1);
        chk("play_valid_early", {31'd0, q_valid}, 32'd0);
        tick();
        chk("play_valid", {31'd0, q_valid}, 32'd1);
        chk("play_data", {16'd0, q_data}, {16'd0, exp});
        tick();
        chk("play_valid_end", {31'd0, q_valid}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        // Reset state
        tick();
        tick();
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_strobes", {27'd0, ce_n, we_n, oe_n, lb_n, ub_n}, 32'h1F);
        chk("rst_misc", {11'd0, q_valid, overrun, loop_end}, 32'd0);
        chk("rst_data", {16'd0, q_data}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Record four samples then close the loop
        pulse_cmd(1'b1, 1'b0);
        chk("enter_rec", {30'd0, state}, 32'd1);
        rec_sample(16'd100, 20'd0);
        rec_sample(16'd200, 20'd1);
        rec_sample(16'd300, 20'd2);
        rec_sample(16'd400, 20'd3);
        pulse_cmd(1'b1, 1'b0);
        chk("enter_play", {30'd0, state}, 32'd2);
        chk("loop_end", {12'd0, loop_end}, 32'd3);
        chk("mem0", {16'd0, mem[0]}, 32'd100);
        chk("mem1", {16'd0, mem[1]}, 32'd200);
        chk("mem2", {16'd0, mem[2]}, 32'd300);
        chk("mem3", {16'd0, mem[3]}, 32'd400);

        // Playback with wrap at loop end
        play_sample(16'd0, 16'd100);
        play_sample(16'd0, 16'd200);
        play_sample(16'd0, 16'd300);
        play_sample(16'd0, 16'd400);
        play_sample(16'd0, 16'd100);
        play_sample(16'd0, 16'd200);
        pulse_cmd(1'b1, 1'b0);
        chk("play_rec_ignored", {30'd0, state}, 32'd2);

        // Stop returns to IDLE and clears playback data
        pulse_cmd(1'b0, 1'b1);
        chk("stop_idle", {30'd0, state}, 32'd0);
        tick();
        chk("idle_data_zero", {16'd0, q_data}, 32'd0);

        // Empty recording collapses to IDLE without any write
        w0 = wr_count;
        pulse_cmd(1'b1, 1'b0);
        pulse_cmd(1'b1, 1'b0);
        chk("empty_rec_idle", {30'd0, state}, 32'd0);
        chk("empty_rec_nowrite", wr_count, w0);

        // Simultaneous rec+stop in REC: stop wins, loop end kept
        pulse_cmd(1'b1, 1'b0);
        rec_sample(16'd7, 20'd0);
        pulse_cmd(1'b1, 1'b1);
        chk("recstop_idle", {30'd0, state}, 32'd0);
        chk("recstop_loop_end", {12'd0, loop_end}, 32'd3);

        // Command during an access is held until the sequencer is free
        pulse_cmd(1'b1, 1'b0);
        sample(16'd55);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("pending_held", {30'd0, state}, 32'd1);
        tick();
        chk("pending_applied", {30'd0, state}, 32'd0);
        chk("pending_mem", {16'd0, mem[0]}, 32'd55);

        // Back-to-back samples: second dropped, sticky overrun
        pulse_cmd(1'b1, 1'b0);
        w0 = wr_count;
        data = 16'd11;
        sample_valid = 1'b1;
        tick();
        chk("ovr_clear_before", {31'd0, overrun}, 32'd0);
        data = 16'd22;
        tick();
        sample_valid = 1'b0;
        chk("ovr_set", {31'd0, overrun}, 32'd1);
        chk("ovr_first_valid", {31'd0, q_valid}, 32'd1);
        tick();
        chk("ovr_second_dropped", {31'd0, q_valid}, 32'd0);
        chk("ovr_one_write", wr_count, w0 + 1);
        chk("ovr_mem", {16'd0, mem[0]}, 32'd11);
        pulse_cmd(1'b0, 1'b1);
        tick();
        tick();
        chk("ovr_sticky", {31'd0, overrun}, 32'd1);

        // Reset in the middle of a write releases strobes at once
        pulse_cmd(1'b1, 1'b0);
        sample(16'd5);
        chk("mid_we", {31'd0, we_n}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_strobes", {27'd0, ce_n, we_n, oe_n, lb_n, ub_n}, 32'h1F);
        chk("mid_rst_state", {30'd0, state}, 32'd0);
        chk("mid_rst_flags", {11'd0, q_valid, overrun, loop_end}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

`ifdef LOOPER_OVERDUB_EN
        // Overdub: saturated mix written back in place
        pulse_cmd(1'b1, 1'b0);
        rec_sample(16'd30000, 20'd0);
        rec_sample(-16'sd100, 20'd1);
        pulse_cmd(1'b1, 1'b0);
        chk("dub_loop_end", {12'd0, loop_end}, 32'd1);
        play_sample(16'd5000, 16'd30000);
        chk("dub_sat_pos", {16'd0, mem[0]}, 32'h7FFF);
        play_sample(16'd50, 16'hFF9C);
        chk("dub_mix_neg", {16'd0, mem[1]}, 32'hFFCE);
        pulse_cmd(1'b0, 1'b1);
        pulse_cmd(1'b1, 1'b0);
        sample(16'd1);
        rst_n = 1'b0;
        #1;
        chk("dub_mid_rst", {27'd0, ce_n, we_n, oe_n, lb_n, ub_n}, 32'h1F);
        tick();
        rst_n = 1'b1;
        tick();
`endif

        chk("no_bus_clash", clash, 0);
        chk("addr_in_range", oob, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
